// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
//
// Several functional units compete to broadcast a finished result (ROB tag +
// value) on a single shared bus. The grant is made combinationally in the
// request cycle, and the winning tag/data are registered so that they appear
// on the bus one cycle later.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst          - synchronous, active-high reset
//   enable       - arbitration enable; 0 suppresses grants this cycle
//   mispredict   - branch flush; suppresses grants and clears the next broadcast
//   req          - per-unit result-ready request [NREQ]
//   req_tag      - per-unit ROB tag, unit i at [i*TAG_W +: TAG_W]
//   req_data     - per-unit result, unit i at [i*DATA_W +: DATA_W]
//   grant        - one-hot (or zero) grant for the current cycle
//   cdb_valid    - broadcast valid
//   cdb_tag      - broadcast ROB tag
//   cdb_data     - broadcast value
//   cdb_src      - index of the unit owning the current broadcast
//   conflict_cnt - saturating count of cycles with two or more requesters
module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mispredict,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  output logic [NREQ-1:0]         grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [PTR_W-1:0]        cdb_src,
  output logic [15:0]             conflict_cnt
);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [PTR_W-1:0]  cdb_src_q;
  logic [15:0]       conflict_cnt_q;

  logic              arb_ok;     // arbitration allowed this cycle
  logic              found;      // some request seen during the search
  logic [PTR_W-1:0]  win_idx;    // winner index from the rotating search
  logic              gnt_any;
  logic              contention;
  int                req_cnt;
  int                idx;

  assign arb_ok = !rst && enable && !mispredict;

  // Rotating priority search: start at rr_ptr and walk upward with wrap,
  // taking the first asserted request.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    req_cnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) req_cnt = req_cnt + 1;
    end
  end

  assign gnt_any    = arb_ok && found;
  assign grant      = gnt_any ? (NREQ'(1) << win_idx) : '0;
  assign contention = arb_ok && (req_cnt >= 2);

  // Pointer moves to the unit just after the winner so it gets lowest
  // priority next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_src_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      // Without a grant the payload holds its last value; only valid drops.
      cdb_valid_q <= gnt_any;
      if (gnt_any) begin
        cdb_tag_q  <= req_tag[win_idx*TAG_W +: TAG_W];
        cdb_data_q <= req_data[win_idx*DATA_W +: DATA_W];
        cdb_src_q  <= win_idx;
      end
      if (contention && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   mispredict;
  logic [NREQ-1:0]        req;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        grant;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;
  logic [15:0]            conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mispredict(mispredict),
    .req(req), .req_tag(req_tag), .req_data(req_data), .grant(grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; registered outputs are
  // stable at that point, and grant is read 1 unit after inputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mispredict = 1'b0; req = 4'b1111;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'h0 || cdb_data !== 32'h0 || cdb_src !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cdb: got v=%b t=%h d=%h s=%0d want all zero", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    n_checks++;
    if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_conflict: got %h want 0000", conflict_cnt); end
    rst = 1'b0; req = 4'b0000;
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0100;
    #1;
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'h7 || cdb_data !== 32'hDEAD_BEEF || cdb_src !== 2'd2) begin
      n_fail++;
      $display("FAIL single_cdb: got v=%b t=%h d=%h s=%0d want v=1 t=7 d=deadbeef s=2", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    // rr_ptr should now be 3, so unit 3 wins with everyone requesting.
    req = 4'b1111;
    #1;
    n_checks++;
    if (grant !== 4'b1000) begin n_fail++; $display("FAIL single_ptr: got %b want 1000", grant); end
    step();
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 4'hA || cdb_data !== 32'h3333_0003 || cdb_src !== 2'd3) begin
      n_fail++;
      $display("FAIL unit3_cdb: got v=%b t=%h d=%h s=%0d want v=1 t=a d=33330003 s=3", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    req = 4'b0000;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL idle_grant: got %b want 0000", grant); end
    step();
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 4'hA || cdb_data !== 32'h3333_0003 || cdb_src !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_hold: got v=%b t=%h d=%h s=%0d want v=0 t=a d=33330003 s=3", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      #1;
      n_checks++;
      if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g); end
      step();
    end
    n_checks++;
    if (conflict_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_conflict: got %0d want 8", conflict_cnt); end
    req = 4'b0000;
  endtask

  task automatic test_mispredict();
    do_reset();
    req = 4'b0011;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL mp_cycle1: got %b want 0001", grant); end
    step();
    mispredict = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL mp_grant: got %b want 0000", grant); end
    n_checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
      n_fail++; $display("FAIL mp_visible: got v=%b s=%0d want v=1 s=0", cdb_valid, cdb_src);
    end
    step();
    mispredict = 1'b0;
    #1;
    n_checks++;
    if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mp_valid: got %b want 0", cdb_valid); end
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL mp_next: got %b want 0010", grant); end
    n_checks++;
    if (conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL mp_conflict: got %0d want 1", conflict_cnt); end
    step();
    req = 4'b0000;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (grant !== 4'b0000) begin n_fail++; $display("FAIL en_grant[%0d]: got %b want 0000", i, grant); end
      step();
      n_checks++;
      if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL en_valid[%0d]: got %b want 0", i, cdb_valid); end
    end
    n_checks++;
    if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL en_conflict: got %0d want 0", conflict_cnt); end
    enable = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL en_first: got %b want 0010", grant); end
    step();
    req = 4'b0000;
  endtask

  task automatic test_saturation();
    do_reset();
    req = 4'b1111;
    repeat (65534) step();
    n_checks++;
    if (conflict_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h want fffe", conflict_cnt); end
    repeat (3) step();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_top: got %h want ffff", conflict_cnt); end
    step();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0011;
    step();
    // Pointer now at 1; reset arrives in a cycle that would grant unit 1.
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0000", grant); end
    step();
    rst = 1'b0;
    n_checks++;
    if (cdb_valid !== 1'b0 || cdb_src !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_cdb: got v=%b s=%0d want v=0 s=0", cdb_valid, cdb_src);
    end
    req = 4'b1001;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b want 0001", grant); end
    step();
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mispredict = 1'b0; req = '0;
    req_tag  = {4'hA, 4'h7, 4'h2, 4'h1};
    req_data = {32'h3333_0003, 32'hDEAD_BEEF, 32'h1111_0001, 32'h0000_0000};
    test_reset();
    test_single_grant();
    test_round_robin();
    test_mispredict();
    test_enable();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
